cavlc_block_sequencer: RTL

Sequences CAVLC decoding of one residual block by generating `cavlc_decoder_state` for the coeff_token, trailing-ones, level, total_zeros and run_before lookup stages. Each cycle it tells the bitstream buffer how many bits to consume. It tracks level index, zeros_left and coefficient write position. It sits between the residual-syntax controller, which issues `start`, and the per-stage combinational LUTs, including total_zeros decoding.

---
 rtl/cavlc_block_sequencer_pkg.sv | 19 +
 rtl/cavlc_run_tracker.sv | 67 ++++++
 rtl/cavlc_block_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cavlc_block_sequencer_pkg.sv
// Shared definitions for the CAVLC residual block sequencer: the decoder state
// encodings seen by the stage LUTs and the datapath widths.
package cavlc_block_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE            = 4'd0,
    ST_COEFF_TOKEN     = 4'd1,
    ST_TRAILING_ONES   = 4'd2,
    ST_LEVEL           = 4'd3,
    ST_TOTAL_ZEROS_LUT = 4'd4,
    ST_RUN_BEFORE      = 4'd5,
    ST_RUN_LAST        = 4'd6,
    ST_DONE            = 4'd7
  } cavlc_state_e;

  localparam int unsigned COEFF_W = 5;  // coefficient count / scan position
  localparam int unsigned ZEROS_W = 4;  // zeros_left, run values, level index

endpackage

// File: rtl/cavlc_run_tracker.sv
// Run-phase bookkeeping for one residual block: zeros_left, the scan position of
// the coefficient being placed, and the count of run_before steps still pending.
module cavlc_run_tracker
  import cavlc_block_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [COEFF_W-1:0] tc_i,
  input  logic [ZEROS_W-1:0] zeros_i,
  input  logic [ZEROS_W-1:0] run_i,
  output logic [ZEROS_W-1:0] zeros_left_o,
  output logic [COEFF_W-1:0] coeff_pos_o,
  output logic [ZEROS_W-1:0] run_cnt_o
);

  logic [ZEROS_W-1:0] zeros_left_q, zeros_left_d;
  logic [COEFF_W-1:0] coeff_pos_q, coeff_pos_d;
  logic [ZEROS_W-1:0] run_cnt_q, run_cnt_d;
  logic [COEFF_W-1:0] tc_m1;

  assign tc_m1 = tc_i - 5'd1;

  always_comb begin
    // NOTE: every next-state value gets a hold default first so no path leaves it unassigned (no latch).
    zeros_left_d = zeros_left_q;
    coeff_pos_d  = coeff_pos_q;
    run_cnt_d    = run_cnt_q;
    if (clear_i) begin
      zeros_left_d = '0;
      coeff_pos_d  = '0;
      run_cnt_d    = '0;
    end else if (load_i) begin
      // Highest occupied scan position: TC coefficients spread over TC+zeros slots.
      zeros_left_d = zeros_i;
      coeff_pos_d  = tc_m1 + {1'b0, zeros_i};
      run_cnt_d    = tc_m1[ZEROS_W-1:0];
    end else if (step_i) begin
      if (zeros_left_q != '0) begin
        zeros_left_d = zeros_left_q - run_i;
        coeff_pos_d  = coeff_pos_q - 5'd1 - {1'b0, run_i};
      end else begin
        coeff_pos_d  = coeff_pos_q - 5'd1;
      end
      run_cnt_d = run_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      zeros_left_q <= '0;
      coeff_pos_q  <= '0;
      run_cnt_q    <= '0;
    end else begin
      zeros_left_q <= zeros_left_d;
      coeff_pos_q  <= coeff_pos_d;
      run_cnt_q    <= run_cnt_d;
    end
  end

  assign zeros_left_o = zeros_left_q;
  assign coeff_pos_o  = coeff_pos_q;
  assign run_cnt_o    = run_cnt_q;

endmodule

// File: rtl/cavlc_block_sequencer.sv
// CAVLC residual block sequencer: walks coeff_token, trailing ones, levels,
// total_zeros and run_before, telling the bitstream buffer how many bits to eat.
// Optional stream checks are compiled in with CAVLC_ERR_CHECK_EN.
module cavlc_block_sequencer
  import cavlc_block_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [COEFF_W-1:0]  max_num_coeff,
  input  logic [COEFF_W-1:0]  total_coeff,
  input  logic [1:0]          trailing_ones,
  input  logic [4:0]          coeff_token_len,
  input  logic [4:0]          level_len,
  input  logic [ZEROS_W-1:0]  total_zeros,
  input  logic [3:0]          total_zeros_len,
  input  logic [ZEROS_W-1:0]  run_before,
  input  logic [3:0]          run_before_len,
  input  logic                bs_stall,
  output logic [3:0]          cavlc_decoder_state,
  output logic                consume_valid,
  output logic [4:0]          consume_len,
  output logic [ZEROS_W-1:0]  level_idx,
  output logic [ZEROS_W-1:0]  zeros_left,
  output logic [COEFF_W-1:0]  coeff_pos,
  output logic                coeff_we,
  output logic                busy,
  output logic                block_done,
  output logic                err
);

  cavlc_state_e       state_q;
  logic [COEFF_W-1:0] tc_q;
  logic [1:0]         t1_q;
  logic [ZEROS_W-1:0] level_idx_q;
  logic               busy_q, block_done_q, err_q;
  logic [ZEROS_W-1:0] run_cnt;
  logic [ZEROS_W-1:0] zeros_load;
  logic [COEFF_W-1:0] tc_m1;
  logic               tc_is_max, zeros_pending;
  logic               err_ct, err_tz, err_rb;

  assign tc_is_max     = (tc_q == max_num_coeff);
  assign zeros_load    = tc_is_max ? '0 : total_zeros;
  assign tc_m1         = tc_q - 5'd1;
  assign zeros_pending = (zeros_left != '0);

`ifdef CAVLC_ERR_CHECK_EN
  logic [COEFF_W-1:0] zeros_max;
  assign zeros_max = max_num_coeff - tc_q;
  assign err_ct    = (total_coeff > max_num_coeff);
  assign err_tz    = !tc_is_max && ({1'b0, total_zeros} > zeros_max);
  assign err_rb    = zeros_pending && (run_before > zeros_left);
`else
  assign err_ct = 1'b0;
  assign err_tz = 1'b0;
  assign err_rb = 1'b0;
`endif

  cavlc_run_tracker u_run_tracker (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (!bs_stall && state_q == ST_IDLE && start),
    .load_i       (!bs_stall && state_q == ST_TOTAL_ZEROS_LUT),
    .step_i       (!bs_stall && state_q == ST_RUN_BEFORE),
    .tc_i         (tc_q),
    .zeros_i      (zeros_load),
    .run_i        (run_before),
    .zeros_left_o (zeros_left),
    .coeff_pos_o  (coeff_pos),
    .run_cnt_o    (run_cnt)
  );

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every branch reads pre-edge values.
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tc_q         <= '0;
      t1_q         <= '0;
      level_idx_q  <= '0;
      busy_q       <= 1'b0;
      block_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else if (!bs_stall) begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_q     <= ST_COEFF_TOKEN;
          busy_q      <= 1'b1;
          level_idx_q <= '0;
          err_q       <= 1'b0;
        end
        ST_COEFF_TOKEN: begin
          tc_q <= total_coeff;
          t1_q <= trailing_ones;
          if (err_ct || total_coeff == '0) begin
            err_q        <= err_ct;
            state_q      <= ST_DONE;
            block_done_q <= 1'b1;
          end else if (trailing_ones != 2'd0) begin
            state_q <= ST_TRAILING_ONES;
          end else begin
            state_q <= ST_LEVEL;
          end
        end
        ST_TRAILING_ONES: begin
          level_idx_q <= {2'b00, t1_q};
          state_q     <= ({3'b000, t1_q} < tc_q) ? ST_LEVEL : ST_TOTAL_ZEROS_LUT;
        end
        ST_LEVEL: begin
          level_idx_q <= level_idx_q + 4'd1;
          if ({1'b0, level_idx_q} == tc_m1) state_q <= ST_TOTAL_ZEROS_LUT;
        end
        ST_TOTAL_ZEROS_LUT: begin
          if (err_tz) begin
            err_q        <= 1'b1;
            state_q      <= ST_DONE;
            block_done_q <= 1'b1;
          end else begin
            state_q <= (tc_q == 5'd1) ? ST_RUN_LAST : ST_RUN_BEFORE;
          end
        end
        ST_RUN_BEFORE: begin
          if (err_rb) begin
            err_q        <= 1'b1;
            state_q      <= ST_DONE;
            block_done_q <= 1'b1;
          end else if (run_cnt == 4'd1) begin
            state_q <= ST_RUN_LAST;
          end
        end
        ST_RUN_LAST: begin
          state_q      <= ST_DONE;
          block_done_q <= 1'b1;
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          block_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Consume and write strobes follow the current state; a stalled buffer sees nothing.
  always_comb begin
    consume_valid = 1'b0;
    consume_len   = '0;
    coeff_we      = 1'b0;
    if (!bs_stall) begin
      case (state_q)
        ST_COEFF_TOKEN: begin
          consume_valid = 1'b1;
          consume_len   = coeff_token_len;
        end
        ST_TRAILING_ONES: begin
          consume_valid = 1'b1;
          consume_len   = {3'b000, t1_q};
        end
        ST_LEVEL: begin
          consume_valid = 1'b1;
          consume_len   = level_len;
        end
        ST_TOTAL_ZEROS_LUT: if (!tc_is_max) begin
          consume_valid = 1'b1;
          consume_len   = {1'b0, total_zeros_len};
        end
        ST_RUN_BEFORE: begin
          coeff_we = 1'b1;
          if (zeros_pending) begin
            consume_valid = 1'b1;
            consume_len   = {1'b0, run_before_len};
          end
        end
        ST_RUN_LAST: coeff_we = 1'b1;
        default: ;
      endcase
    end
  end

  assign cavlc_decoder_state = state_q;
  assign level_idx           = level_idx_q;
  assign busy                = busy_q;
  assign block_done          = block_done_q;
  assign err                 = err_q;

endmodule
